// File: rtl/qea_state_readout.sv
// -----------------------------------------------------------------------------
// qea_state_readout
//
// Readout stage behind the QEA core. Once the QEA core signals completion, this
// block reads every row of the state RAM through the QEA state port. For each
// row it turns the PE_NUM complex Q2.30 amplitudes into squared magnitudes
// (measurement probabilities). It streams those rows out on a valid/ready
// interface and keeps a running sum of everything the consumer has accepted.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           one-cycle readout request (honoured only in IDLE)
//   i_qbit_num        qubit count; latched at i_start
//   i_complete        QEA completion level; gates the start of reading
//   o_state_ena/wea   per-PE read enable (all ones or all zeros); write enable = 0
//   o_state_addra     state RAM row address
//   i_state_dout      row data; PE k at [k*2*DW +: 2*DW], real part upper, imag lower
//   o_prob_*          output row stream: valid/ready, data, row index, last flag
//   o_norm_sum        sum of all accepted probabilities since the last i_start
//   o_busy            readout in progress (WAIT, READ, DRAIN)
//   o_done            one-cycle pulse when the last row handshakes
//
// State table
//   IDLE  | waiting for i_start
//   WAIT  | request taken; waiting for i_complete
//   READ  | issuing row reads 0..N-1, limited by FIFO credit
//   DRAIN | all reads issued; waiting for the last row to be accepted
// -----------------------------------------------------------------------------
module qea_state_readout #(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int NUM_FRAC_BIT     = 30,
    parameter int RD_LATENCY       = 1,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]                           i_qbit_num,
    input  logic                                                i_complete,
    output logic [PE_NUM-1:0]                                   o_state_ena,
    output logic [PE_NUM-1:0]                                   o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]                         o_state_addra,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]                      i_state_dout,
    output logic                                                o_prob_valid,
    input  logic                                                i_prob_ready,
    output logic [PE_NUM*DATA_WIDTH-1:0]                        o_prob_data,
    output logic [STATE_ADDR_WIDTH-1:0]                         o_prob_addr,
    output logic                                                o_prob_last,
    output logic [DATA_WIDTH+STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_norm_sum,
    output logic                                                o_busy,
    output logic                                                o_done
);

    localparam int ROW_W  = PE_NUM * DATA_WIDTH;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int MAG_W  = 2 * DATA_WIDTH + 1;
    localparam int NORM_W = DATA_WIDTH + STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [STATE_ADDR_WIDTH-1:0] last_row_q, last_row_d;
    logic [STATE_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [STATE_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [RD_LATENCY-1:0]       rd_pipe_q, rd_pipe_d;
    logic                        p_vld_q, p_vld_d;
    logic [ROW_W-1:0]            p_data_q, p_data_d;
    logic [CNT_W-1:0]            outstanding_q, outstanding_d;
    logic [CNT_W-1:0]            fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [NORM_W-1:0]           norm_q, norm_d;

    logic [ROW_W-1:0]            fifo_mem [FIFO_DEPTH];

    logic                        prob_valid;
    logic                        accept;
    logic                        push;
    logic                        credit_ok;
    logic                        issue;
    logic                        row_last;
    logic                        data_vld;
    logic [ROW_W-1:0]            fifo_head;
    logic [ROW_W-1:0]            p_calc;
    logic [NORM_W-1:0]           row_sum;
    logic [STATE_ADDR_WIDTH-1:0] last_row_calc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Squared magnitude per PE. The sum of two squares is never negative, so
    // the products are zero-extended into the wider sum.
    for (genvar k = 0; k < PE_NUM; k++) begin : g_pe
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
        logic signed [PROD_W-1:0]     re_sq;
        logic signed [PROD_W-1:0]     im_sq;
        logic [MAG_W-1:0]             mag;
        logic [MAG_W-1:0]             mag_sh;

        assign re     = i_state_dout[k*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
        assign im     = i_state_dout[k*2*DATA_WIDTH +: DATA_WIDTH];
        assign re_sq  = PROD_W'(re) * PROD_W'(re);
        assign im_sq  = PROD_W'(im) * PROD_W'(im);
        assign mag    = {1'b0, re_sq} + {1'b0, im_sq};
        assign mag_sh = mag >> NUM_FRAC_BIT;
        assign p_calc[k*DATA_WIDTH +: DATA_WIDTH] =
            (|mag_sh[MAG_W-1:DATA_WIDTH]) ? '1 : mag_sh[DATA_WIDTH-1:0];
    end

    // N-1 as a mask: bit i is set when the row-address exponent exceeds i.
    always_comb begin
        last_row_calc = '0;
        for (int i = 0; i < STATE_ADDR_WIDTH; i++) begin
            last_row_calc[i] = (int'(i_qbit_num) > (i + PE_NUM_WIDTH));
        end
    end

    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign prob_valid = (fifo_cnt_q != '0);
    assign accept     = prob_valid & i_prob_ready;
    assign push       = p_vld_q;
    assign row_last   = (out_addr_q == last_row_q);
    assign data_vld   = rd_pipe_q[RD_LATENCY-1];

    // Reads in flight (RAM pipeline plus compute register) hold a FIFO slot
    // in reserve, so a row is never issued that the FIFO could not take.
    assign credit_ok = (({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < (CNT_W+1)'(FIFO_DEPTH));
    assign issue     = (state_q == S_READ) && credit_ok;

    always_comb begin
        row_sum = '0;
        for (int k = 0; k < PE_NUM; k++) begin
            row_sum = row_sum + NORM_W'(fifo_head[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_comb begin
        state_d    = state_q;
        last_row_d = last_row_q;
        rd_addr_d  = rd_addr_q;
        out_addr_d = out_addr_q;
        norm_d     = norm_q;

        if (accept) begin
            norm_d     = norm_q + row_sum;
            out_addr_d = row_last ? '0 : out_addr_q + STATE_ADDR_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_WAIT;
                    last_row_d = last_row_calc;
                    rd_addr_d  = '0;
                    out_addr_d = '0;
                    norm_d     = '0;
                end
            end
            S_WAIT: begin
                if (i_complete) state_d = S_READ;
            end
            S_READ: begin
                if (issue) begin
                    if (rd_addr_q == last_row_q) state_d = S_DRAIN;
                    else rd_addr_d = rd_addr_q + STATE_ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (accept && row_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_pipe_d    = '0;
        rd_pipe_d[0] = issue;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
        p_vld_d       = data_vld;
        p_data_d      = data_vld ? p_calc : p_data_q;
        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(push);
        fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(accept);
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = accept ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_row_q    <= '0;
            rd_addr_q     <= '0;
            out_addr_q    <= '0;
            rd_pipe_q     <= '0;
            p_vld_q       <= 1'b0;
            p_data_q      <= '0;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            norm_q        <= '0;
        end else begin
            state_q       <= state_d;
            last_row_q    <= last_row_d;
            rd_addr_q     <= rd_addr_d;
            out_addr_q    <= out_addr_d;
            rd_pipe_q     <= rd_pipe_d;
            p_vld_q       <= p_vld_d;
            p_data_q      <= p_data_d;
            outstanding_q <= outstanding_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            norm_q        <= norm_d;
        end
    end

    // Storage needs no reset: the occupancy count decides what is visible.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= p_data_q;
    end

    assign o_state_ena   = {PE_NUM{issue}};
    assign o_state_wea   = '0;
    assign o_state_addra = rd_addr_q;
    assign o_prob_valid  = prob_valid;
    assign o_prob_data   = prob_valid ? fifo_head : '0;
    assign o_prob_addr   = out_addr_q;
    assign o_prob_last   = prob_valid & row_last;
    assign o_norm_sum    = norm_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DRAIN) & accept & row_last;

endmodule

// File: tb/tb_qea_state_readout.sv
module tb_qea_state_readout;

    localparam int PE_NUM = 4;
    localparam int DW     = 32;
    localparam int SAW    = 16;
    localparam int QW     = 6;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 4;
    localparam int NORM_W = DW + SAW + 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     i_start;
    logic [QW-1:0]            i_qbit_num;
    logic                     i_complete;
    logic [PE_NUM-1:0]        o_state_ena;
    logic [PE_NUM-1:0]        o_state_wea;
    logic [SAW-1:0]           o_state_addra;
    logic [PE_NUM*2*DW-1:0]   i_state_dout = '0;
    logic                     o_prob_valid;
    logic                     i_prob_ready;
    logic [PE_NUM*DW-1:0]     o_prob_data;
    logic [SAW-1:0]           o_prob_addr;
    logic                     o_prob_last;
    logic [NORM_W-1:0]        o_norm_sum;
    logic                     o_busy;
    logic                     o_done;

    always #5 clk = ~clk;

    qea_state_readout #(
        .RD_LATENCY (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_qbit_num    (i_qbit_num),
        .i_complete    (i_complete),
        .o_state_ena   (o_state_ena),
        .o_state_wea   (o_state_wea),
        .o_state_addra (o_state_addra),
        .i_state_dout  (i_state_dout),
        .o_prob_valid  (o_prob_valid),
        .i_prob_ready  (i_prob_ready),
        .o_prob_data   (o_prob_data),
        .o_prob_addr   (o_prob_addr),
        .o_prob_last   (o_prob_last),
        .o_norm_sum    (o_norm_sum),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    typedef struct packed {
        logic [SAW-1:0]       addr;
        logic [PE_NUM*DW-1:0] data;
        logic                 last;
    } row_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    row_t          sb [$];
    row_t          mon_e;
    logic [255:0]  ram [0:63];
    logic [NORM_W-1:0] exp_norm;
    int            tb_cyc = 0;
    int            issued = 0;
    int            accepted = 0;
    int            done_cnt = 0;
    int            first_ena_cyc = -1;
    int            first_vld_cyc = -1;
    int            done_cyc = -1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: p = (re^2 + im^2) >> 30, saturated to 32 bits.
    function automatic logic [31:0] prob_model(input logic [63:0] amp);
        longint      re, im;
        logic [64:0] s;
        re = longint'($signed(amp[63:32]));
        im = longint'($signed(amp[31:0]));
        s  = 65'(re * re) + 65'(im * im);
        s  = s >> 30;
        if (s > 65'h0_FFFF_FFFF) return 32'hFFFF_FFFF;
        return s[31:0];
    endfunction

    task automatic load_expect(input int n);
        row_t        e;
        logic [31:0] p;
        exp_norm = '0;
        for (int r = 0; r < n; r++) begin
            e      = '0;
            e.addr = SAW'(r);
            e.last = (r == n - 1);
            for (int k = 0; k < PE_NUM; k++) begin
                p = prob_model(ram[r][k*64 +: 64]);
                e.data[k*32 +: 32] = p;
                exp_norm = exp_norm + NORM_W'(p);
            end
            sb.push_back(e);
        end
        first_ena_cyc = -1;
        first_vld_cyc = -1;
        done_cyc      = -1;
    endtask

    task automatic start_readout(input int qb);
        @(posedge clk); #1;
        i_qbit_num = QW'(qb);
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start    = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
    task automatic wait_done(input string tag, input int mode, input int budget);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < budget && done_cnt == d0; k++) begin
            @(posedge clk); #1;
            if (mode == 1) i_prob_ready = (tb_cyc % 4 == 0) || (tb_cyc % 4 == 3);
            else           i_prob_ready = 1'b1;
        end
        chk({tag, "_done_cnt"}, 256'(done_cnt - d0), 256'(1));
        chk({tag, "_sb_empty"}, 256'(sb.size()), 256'(0));
        chk({tag, "_norm_sum"}, 256'(o_norm_sum), 256'(exp_norm));
        chk({tag, "_busy_after"}, 256'(o_busy), 256'(0));
        i_prob_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_single_done"}, 256'(done_cnt - d0), 256'(1));
    endtask

    task automatic chk_latency(input string tag, input int n);
        chk({tag, "_rd_to_valid"}, 256'(first_vld_cyc - first_ena_cyc), 256'(RD_LAT + 2));
        chk({tag, "_rd_to_done"}, 256'(done_cyc - first_ena_cyc), 256'(n + RD_LAT + 1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, 256'({o_state_ena, o_state_addra, o_prob_valid, o_prob_data, o_prob_addr,
                       o_prob_last, o_norm_sum, o_busy, o_done}), 256'(0));
    endtask

    // State RAM model
    always @(posedge clk) begin
        tb_cyc++;
        if (o_state_ena[0]) i_state_dout <= ram[o_state_addra[5:0]];
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            issued   = 0;
            accepted = 0;
        end else begin
            if (o_state_ena !== '0) begin
                chk("ena_all_pe", 256'(o_state_ena), 256'(4'hF));
                issued++;
                if (first_ena_cyc < 0) first_ena_cyc = tb_cyc;
            end
            chk("credit_bound", 256'((issued - accepted) <= DEPTH), 256'(1));
            if (o_prob_valid) begin
                if (first_vld_cyc < 0) first_vld_cyc = tb_cyc;
                if (sb.size() == 0) begin
                    chk("extra_row", 256'(o_prob_valid), 256'(0));
                end else begin
                    mon_e = sb[0];
                    chk("row_data", 256'(o_prob_data), 256'(mon_e.data));
                    chk("row_addr", 256'(o_prob_addr), 256'(mon_e.addr));
                    chk("row_last", 256'(o_prob_last), 256'(mon_e.last));
                    chk("done_on_last", 256'(o_done), 256'(i_prob_ready & mon_e.last));
                    if (i_prob_ready) begin
                        void'(sb.pop_front());
                        accepted++;
                    end
                end
            end else begin
                chk("done_no_valid", 256'(o_done), 256'(0));
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = tb_cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", tb_cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_cyc;
        int d0;
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_qbit_num   = '0;
        i_complete   = 1'b0;
        i_prob_ready = 1'b1;
        for (int r = 0; r < 64; r++) ram[r] = '0;
        #2;
        chk_reset_vals("reset_values");
        chk("wea_tied_low", 256'(o_state_wea), 256'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basis state |0>, 8 qubits
        ram[0][63:32] = 32'h4000_0000;
        load_expect(64);
        i_complete = 1'b1;
        start_readout(8);
        wait_done("basis", 0, 400);
        chk("basis_norm_value", 256'(o_norm_sum), 256'(32'h4000_0000));
        chk_latency("basis", 64);

        // Uniform superposition, 4 qubits, with completion gating
        for (int r = 0; r < 64; r++) ram[r] = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < PE_NUM; k++) ram[r][k*64 +: 64] = {32'h1000_0000, 32'h0};
        load_expect(4);
        i_complete = 1'b0;
        start_readout(4);
        repeat (20) begin
            @(negedge clk);
            chk("gate_no_read", 256'(o_state_ena), 256'(0));
        end
        chk("gate_busy", 256'(o_busy), 256'(1));
        @(posedge clk); #1;
        i_complete = 1'b1;
        rise_cyc   = tb_cyc;
        wait_done("uniform", 0, 100);
        chk("uniform_norm_value", 256'(o_norm_sum), 256'(32'h4000_0000));
        chk("gate_first_read", 256'(first_ena_cyc - rise_cyc), 256'(1));
        chk_latency("uniform", 4);

        // Backpressure with random amplitudes
        for (int r = 0; r < 64; r++)
            for (int k = 0; k < PE_NUM; k++) ram[r][k*64 +: 64] = {$urandom, $urandom};
        load_expect(64);
        start_readout(8);
        wait_done("bp", 1, 1000);

        // Saturation and magnitude boundaries, 2 qubits
        for (int r = 0; r < 64; r++) ram[r] = '0;
        ram[0][0*64 +: 64] = {32'h8000_0000, 32'h8000_0000};
        ram[0][1*64 +: 64] = {32'h4000_0000, 32'h4000_0000};
        ram[0][2*64 +: 64] = {32'hC000_0000, 32'h0000_0000};
        ram[0][3*64 +: 64] = {32'h7FFF_FFFF, 32'h7FFF_FFFF};
        load_expect(1);
        chk("model_half_sq", 256'(sb[0].data[63:32]), 256'(32'h8000_0000));
        start_readout(2);
        wait_done("sat", 0, 100);
        chk_latency("sat", 1);

        // Reset mid-readout
        for (int r = 0; r < 64; r++)
            for (int k = 0; k < PE_NUM; k++) ram[r][k*64 +: 64] = {$urandom, $urandom};
        load_expect(64);
        start_readout(8);
        for (int k = 0; k < 200 && accepted < 10; k++) begin
            @(posedge clk); #1;
        end
        chk("rst_reached_row10", 256'(accepted >= 10), 256'(1));
        d0    = done_cnt;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid_values");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_idle_no_read", 256'({o_busy, o_state_ena}), 256'(0));
        end
        chk("rst_no_done", 256'(done_cnt - d0), 256'(0));
        load_expect(64);
        start_readout(8);
        wait_done("rst_rerun", 0, 400);
        chk_latency("rst_rerun", 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
